// File: rtl/fetch_slice_pkg.sv
// Shared types and constants for the instruction fetch slice.
// The state encoding, bubble word and default reset PC all live here.
package fetch_slice_pkg;

  localparam int unsigned XLEN = 16;

  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 16'hF000;
  localparam logic [XLEN-1:0] RESET_PC_DEF  = 16'h0000;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_inc;
  } ifid_word_t;

  // Word-addressed increment; 16'hFFFF rolls over to 16'h0000 silently.
  function automatic logic [XLEN-1:0] pc_plus1(input logic [XLEN-1:0] pc);
    return pc + 16'h0001;
  endfunction

endpackage

// File: rtl/fetch_slice_if.sv
// Bundle of instruction-memory, decode-feedback and IF/ID signals.
// The master side is the fetch slice; the slave side is memory plus decode.
interface fetch_slice_if;
  import fetch_slice_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rdy;
  logic [XLEN-1:0] imem_data;
  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] PC_inc;
  logic            if_valid;

  modport master (
    output imem_req, imem_addr, instr, PC_inc, if_valid,
    input  imem_rdy, imem_data, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr, PC_inc, if_valid,
    output imem_rdy, imem_data, stall, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_slice_if_id_reg.sv
// IF/ID pipeline register: load a new word, hold, or flush to a bubble.
// A flush keeps PC_inc so the last real return address stays visible.
module if_id_reg
  import fetch_slice_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            flush_i,
  input  ifid_word_t      d_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_inc_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_inc_q;
  logic            valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q  <= NOP_INSTR;
      pc_inc_q <= 16'h0000;
      valid_q  <= 1'b0;
    end else if (flush_i) begin
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
    end else if (load_i) begin
      instr_q  <= d_i.instr;
      pc_inc_q <= d_i.pc_inc;
      valid_q  <= 1'b1;
    end else begin
      instr_q  <= instr_q;
      pc_inc_q <= pc_inc_q;
      valid_q  <= valid_q;
    end
  end

  assign instr_o  = instr_q;
  assign pc_inc_o = pc_inc_q;
  assign valid_o  = valid_q;

endmodule

// File: rtl/fetch_slice.sv
// Instruction fetch stage: PC sequencing, stall skid buffer and redirect handling.
// Requests are never cancelled; a redirect during an outstanding fetch drains it in DISCARD.
module fetch_slice
  import fetch_slice_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic         clk,
  input  logic         rst,
  fetch_slice_if.master bus
);

  localparam logic [1:0] ST_FETCH   = S_FETCH;
  localparam logic [1:0] ST_HOLD    = S_HOLD;
  localparam logic [1:0] ST_DISCARD = S_DISCARD;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] stale_q, stale_d;
  ifid_word_t      skid_q, skid_d;

  logic            ifid_load;
  logic            ifid_flush;
  ifid_word_t      ifid_d;
  logic [XLEN-1:0] pc_inc;

  assign pc_inc = pc_plus1(pc_q);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    stale_d       = stale_q;
    skid_d        = skid_q;
    ifid_load     = 1'b0;
    ifid_flush    = 1'b0;
    ifid_d.instr  = bus.imem_data;
    ifid_d.pc_inc = pc_inc;
    case (state_q)
      ST_FETCH: begin
        if (bus.redirect) begin
          ifid_flush = 1'b1;
          pc_d       = bus.redirect_pc;
          skid_d     = '0;
          if (bus.imem_rdy) begin
            state_d = ST_FETCH;
          end else begin
            stale_d = pc_q;
            state_d = ST_DISCARD;
          end
        end else if (bus.imem_rdy) begin
          pc_d = pc_inc;
          if (bus.stall) begin
            skid_d.instr  = bus.imem_data;
            skid_d.pc_inc = pc_inc;
            state_d       = ST_HOLD;
          end else begin
            ifid_load = 1'b1;
          end
        end else begin
          // Nothing arrived: decode sees a bubble unless it is holding its word.
          ifid_flush = ~bus.stall;
        end
      end
      ST_HOLD: begin
        if (bus.redirect) begin
          ifid_flush = 1'b1;
          pc_d       = bus.redirect_pc;
          skid_d     = '0;
          state_d    = ST_FETCH;
        end else if (!bus.stall) begin
          ifid_d    = skid_q;
          ifid_load = 1'b1;
          state_d   = ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DISCARD: begin
        ifid_flush = 1'b1;
        if (bus.redirect) begin
          pc_d = bus.redirect_pc;
        end else begin
          pc_d = pc_q;
        end
        if (bus.imem_rdy) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      default: begin
        ifid_flush = 1'b1;
        state_d    = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      stale_q <= 16'h0000;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.imem_req  = (state_q != ST_HOLD);
  assign bus.imem_addr = (state_q == ST_DISCARD) ? stale_q : pc_q;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (ifid_load),
    .flush_i  (ifid_flush),
    .d_i      (ifid_d),
    .instr_o  (bus.instr),
    .pc_inc_o (bus.PC_inc),
    .valid_o  (bus.if_valid)
  );

endmodule

// File: tb/tb_fetch_slice.sv
// Scenario bench for fetch_slice: expected IF/ID words are queued when the fetch
// is driven and popped whenever decode consumes a valid, unstalled word.
module tb_fetch_slice;
  import fetch_slice_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_slice_if fif ();
  fetch_slice_if wif ();

  int total = 0;
  int bad   = 0;
  logic [31:0] sb_q[$];

  function automatic logic [15:0] memword(input logic [15:0] a);
    return 16'h1000 + a;
  endfunction

  assign fif.imem_data   = fif.imem_rdy ? memword(fif.imem_addr) : 16'hDEAD;
  assign wif.imem_data   = memword(wif.imem_addr);
  assign wif.imem_rdy    = 1'b1;
  assign wif.stall       = 1'b0;
  assign wif.redirect    = 1'b0;
  assign wif.redirect_pc = 16'h0000;

  fetch_slice #(.RESET_PC(16'h0000), .NOP_INSTR(16'hF000)) dut (
    .clk (clk), .rst (rst), .bus (fif)
  );

  fetch_slice #(.RESET_PC(16'hFFFE), .NOP_INSTR(16'hF000)) dut_wrap (
    .clk (clk), .rst (rst), .bus (wif)
  );

  // Advance one cycle; if decode takes the current IF/ID word, score it.
  task automatic tick();
    logic        consumed;
    logic [31:0] got;
    logic [31:0] exp;
    consumed = fif.if_valid && !fif.stall;
    got      = {fif.instr, fif.PC_inc};
    @(posedge clk);
    #1;
    if (consumed) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got=%h expected=none", got);
      end else begin
        exp = sb_q.pop_front();
        if (got !== exp) begin
          bad++;
          $display("FAIL sb_order got=%h expected=%h", got, exp);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    fif.imem_rdy = 1'b0; fif.stall = 1'b0; fif.redirect = 1'b0; fif.redirect_pc = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    total++; if (fif.instr !== 16'hF000) begin bad++; $display("FAIL rst_instr got=%h expected=f000", fif.instr); end
    total++; if (fif.PC_inc !== 16'h0000) begin bad++; $display("FAIL rst_pcinc got=%h expected=0000", fif.PC_inc); end
    total++; if (fif.if_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b expected=0", fif.if_valid); end
    rst = 1'b1;
    #1;
    total++; if (fif.imem_req !== 1'b1) begin bad++; $display("FAIL rst_req got=%b expected=1", fif.imem_req); end
    total++; if (fif.imem_addr !== 16'h0000) begin bad++; $display("FAIL rst_addr got=%h expected=0000", fif.imem_addr); end
  endtask

  task automatic test_stream();
    fif.imem_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (fif.imem_addr !== 16'(i)) begin bad++; $display("FAIL stream_addr got=%h expected=%h", fif.imem_addr, 16'(i)); end
      sb_q.push_back({memword(16'(i)), 16'(i + 1)});
      tick();
      total++; if (fif.instr !== memword(16'(i))) begin bad++; $display("FAIL stream_instr got=%h expected=%h", fif.instr, memword(16'(i))); end
      total++; if (fif.PC_inc !== 16'(i + 1)) begin bad++; $display("FAIL stream_pcinc got=%h expected=%h", fif.PC_inc, 16'(i + 1)); end
      total++; if (fif.if_valid !== 1'b1) begin bad++; $display("FAIL stream_valid got=%b expected=1", fif.if_valid); end
    end
  endtask

  task automatic test_stall();
    fif.stall = 1'b1;
    total++; if (fif.imem_addr !== 16'h0004) begin bad++; $display("FAIL stall_addr got=%h expected=0004", fif.imem_addr); end
    sb_q.push_back({memword(16'h0004), 16'h0005});
    tick();
    total++; if (fif.instr !== memword(16'h0003)) begin bad++; $display("FAIL stall_hold_instr got=%h expected=%h", fif.instr, memword(16'h0003)); end
    total++; if (fif.PC_inc !== 16'h0004) begin bad++; $display("FAIL stall_hold_pcinc got=%h expected=0004", fif.PC_inc); end
    total++; if (fif.imem_req !== 1'b0) begin bad++; $display("FAIL stall_req got=%b expected=0", fif.imem_req); end
    tick();
    tick();
    total++; if (fif.instr !== memword(16'h0003) || fif.if_valid !== 1'b1) begin bad++; $display("FAIL stall_keep got=%h/%b expected=%h/1", fif.instr, fif.if_valid, memword(16'h0003)); end
    fif.stall = 1'b0;
    tick();
    total++; if (fif.instr !== memword(16'h0004)) begin bad++; $display("FAIL skid_instr got=%h expected=%h", fif.instr, memword(16'h0004)); end
    total++; if (fif.PC_inc !== 16'h0005) begin bad++; $display("FAIL skid_pcinc got=%h expected=0005", fif.PC_inc); end
    total++; if (fif.imem_addr !== 16'h0005) begin bad++; $display("FAIL skid_next_addr got=%h expected=0005", fif.imem_addr); end
    sb_q.push_back({memword(16'h0005), 16'h0006});
    tick();
    total++; if (fif.instr !== memword(16'h0005)) begin bad++; $display("FAIL post_stall_instr got=%h expected=%h", fif.instr, memword(16'h0005)); end
    sb_q.push_back({memword(16'h0006), 16'h0007});
    tick();
  endtask

  task automatic test_redirect_wait();
    fif.imem_rdy = 1'b0;
    total++; if (fif.imem_addr !== 16'h0007) begin bad++; $display("FAIL wait_addr got=%h expected=0007", fif.imem_addr); end
    tick();
    total++; if (fif.if_valid !== 1'b0 || fif.instr !== 16'hF000) begin bad++; $display("FAIL wait_bubble got=%h/%b expected=f000/0", fif.instr, fif.if_valid); end
    fif.redirect = 1'b1; fif.redirect_pc = 16'h0040;
    tick();
    fif.redirect = 1'b0;
    total++; if (fif.imem_addr !== 16'h0007) begin bad++; $display("FAIL discard_addr got=%h expected=0007", fif.imem_addr); end
    total++; if (fif.imem_req !== 1'b1) begin bad++; $display("FAIL discard_req got=%b expected=1", fif.imem_req); end
    tick();
    total++; if (fif.imem_addr !== 16'h0007 || fif.if_valid !== 1'b0) begin bad++; $display("FAIL discard_wait got=%h/%b expected=0007/0", fif.imem_addr, fif.if_valid); end
    fif.imem_rdy = 1'b1;
    tick();
    total++; if (fif.imem_addr !== 16'h0040) begin bad++; $display("FAIL redir_addr got=%h expected=0040", fif.imem_addr); end
    total++; if (fif.if_valid !== 1'b0) begin bad++; $display("FAIL drop_valid got=%b expected=0", fif.if_valid); end
    sb_q.push_back({memword(16'h0040), 16'h0041});
    tick();
    total++; if (fif.instr !== memword(16'h0040) || fif.PC_inc !== 16'h0041) begin bad++; $display("FAIL redir_instr got=%h/%h expected=%h/0041", fif.instr, fif.PC_inc, memword(16'h0040)); end
    tick();
  endtask

  task automatic test_redirect_hold();
    fif.stall = 1'b1;
    total++; if (fif.imem_addr !== 16'h0042) begin bad++; $display("FAIL hold_addr got=%h expected=0042", fif.imem_addr); end
    tick();
    total++; if (fif.instr !== memword(16'h0041) || fif.imem_req !== 1'b0) begin bad++; $display("FAIL hold_state got=%h/%b expected=%h/0", fif.instr, fif.imem_req, memword(16'h0041)); end
    fif.redirect = 1'b1; fif.redirect_pc = 16'h0080;
    tick();
    fif.redirect = 1'b0; fif.stall = 1'b0;
    total++; if (fif.if_valid !== 1'b0 || fif.instr !== 16'hF000) begin bad++; $display("FAIL hold_redir_bubble got=%h/%b expected=f000/0", fif.instr, fif.if_valid); end
    total++; if (fif.imem_addr !== 16'h0080 || fif.imem_req !== 1'b1) begin bad++; $display("FAIL hold_redir_addr got=%h/%b expected=0080/1", fif.imem_addr, fif.imem_req); end
    sb_q.push_back({memword(16'h0080), 16'h0081});
    tick();
    total++; if (fif.instr !== memword(16'h0080)) begin bad++; $display("FAIL hold_redir_instr got=%h expected=%h", fif.instr, memword(16'h0080)); end
    sb_q.push_back({memword(16'h0081), 16'h0082});
    tick();
    total++; if (fif.PC_inc !== 16'h0082) begin bad++; $display("FAIL hold_redir_pcinc got=%h expected=0082", fif.PC_inc); end
    fif.imem_rdy = 1'b0;
    tick();
    total++; if (fif.if_valid !== 1'b0 || fif.PC_inc !== 16'h0082) begin bad++; $display("FAIL bubble_pcinc got=%h/%b expected=0082/0", fif.PC_inc, fif.if_valid); end
  endtask

  task automatic test_reset_mid_wait();
    total++; if (fif.imem_addr !== 16'h0082) begin bad++; $display("FAIL midwait_addr got=%h expected=0082", fif.imem_addr); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (fif.instr !== 16'hF000 || fif.if_valid !== 1'b0) begin bad++; $display("FAIL async_ifid got=%h/%b expected=f000/0", fif.instr, fif.if_valid); end
    total++; if (fif.PC_inc !== 16'h0000) begin bad++; $display("FAIL async_pcinc got=%h expected=0000", fif.PC_inc); end
    total++; if (fif.imem_addr !== 16'h0000) begin bad++; $display("FAIL async_addr got=%h expected=0000", fif.imem_addr); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++; if (fif.imem_req !== 1'b1 || fif.imem_addr !== 16'h0000) begin bad++; $display("FAIL release_req got=%b/%h expected=1/0000", fif.imem_req, fif.imem_addr); end
  endtask

  task automatic test_wrap();
    logic [15:0] addr_exp;
    total++; if (wif.imem_addr !== 16'hFFFE || wif.imem_req !== 1'b1) begin bad++; $display("FAIL wrap_first got=%h/%b expected=fffe/1", wif.imem_addr, wif.imem_req); end
    addr_exp = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (wif.instr !== memword(addr_exp) || wif.if_valid !== 1'b1) begin bad++; $display("FAIL wrap_instr got=%h/%b expected=%h/1", wif.instr, wif.if_valid, memword(addr_exp)); end
      addr_exp = addr_exp + 16'h0001;
      total++; if (wif.PC_inc !== addr_exp) begin bad++; $display("FAIL wrap_pcinc got=%h expected=%h", wif.PC_inc, addr_exp); end
      total++; if (wif.imem_addr !== addr_exp) begin bad++; $display("FAIL wrap_addr got=%h expected=%h", wif.imem_addr, addr_exp); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_reset_mid_wait();
    test_wrap();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d expected=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
